// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg : shared MDU state encodings and defaults    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_exe;
    logic exe_mem;
    logic mem_wb;
  } stall_t;

  typedef struct packed {
    logic if_id;
    logic id_exe;
  } flush_t;

  // BUSY spans LAT-1 cycles, so the counter is preloaded with LAT-1
  function automatic int lat_load(input int lat);
    return lat - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mdu_seq_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdu_seq_fsm : mul/div sequencing FSM with latency down-counter    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mdu_seq_fsm
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CW      = $clog2(DIV_LAT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_i,
  input  logic       is_div_i,
  output logic       mdu_start_o,
  output logic       mdu_busy_o,
  output logic       mdu_done_o,
  output mdu_state_e state_o
);

  localparam logic [CW-1:0] MUL_LOAD = CW'(lat_load(MUL_LAT));
  localparam logic [CW-1:0] DIV_LOAD = CW'(lat_load(DIV_LAT));
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          start_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept_i) begin
            state_q <= BUSY;
            cnt_q   <= is_div_i ? DIV_LOAD : MUL_LOAD;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          // leave on the decrement that reaches zero so DONE lands exactly LAT cycles after accept
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_start_o = start_q;
  assign mdu_busy_o  = busy_q;
  assign mdu_done_o  = done_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush scheduler for the 5-stage pipeline |
// | Optional perf counters: HAZ_PERF_CNT_EN            Rev 1.0       |
// +------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic [4:0]       num_write_EXE,
  input  logic             mem_read_EXE,
  input  logic             reg_write_EXE,
  input  logic             branch_taken_EXE,
  input  logic             mdu_start_ID,
  input  logic             mdu_is_div_ID,
  input  logic             mdu_read_ID,
  input  logic             dmem_wait,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EXE,
  output logic             stall_EXE_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EXE,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_mdu
);

  mdu_state_e w_state;
  logic       w_lu;
  logic       w_mh;
  logic       w_accept;
  stall_t     w_stall;
  flush_t     w_flush;

  assign w_lu = mem_read_EXE && reg_write_EXE && (num_write_EXE != 5'd0) &&
                ((use_rs_ID && (rs_ID == num_write_EXE)) ||
                 (use_rt_ID && (rt_ID == num_write_EXE)));

  assign w_mh = (w_state == BUSY) && (mdu_start_ID || mdu_read_ID);

  // A stalled or wrong-path MDU op stays in ID and is re-presented later, so only accept a clean one
  assign w_accept = rst_n && mdu_start_ID && !dmem_wait && !branch_taken_EXE &&
                    !w_mh && !w_lu;

  always_comb begin
    w_stall = '0;
    w_flush = '0;
    if (!rst_n) begin
      w_stall = '0;
      w_flush = '0;
    end else if (dmem_wait) begin
      w_stall = '1;
    end else if (branch_taken_EXE) begin
      w_flush = '1;
    end else if (w_mh || w_lu) begin
      w_stall.pc     = 1'b1;
      w_stall.if_id  = 1'b1;
      w_flush.id_exe = 1'b1;
    end
  end

  assign stall_PC      = w_stall.pc;
  assign stall_IF_ID   = w_stall.if_id;
  assign stall_ID_EXE  = w_stall.id_exe;
  assign stall_EXE_MEM = w_stall.exe_mem;
  assign stall_MEM_WB  = w_stall.mem_wb;
  assign flush_IF_ID   = w_flush.if_id;
  assign flush_ID_EXE  = w_flush.id_exe;

  mdu_seq_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu_seq_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (w_accept),
    .is_div_i    (mdu_is_div_ID),
    .mdu_start_o (mdu_start),
    .mdu_busy_o  (mdu_busy),
    .mdu_done_o  (mdu_done),
    .state_o     (w_state)
  );

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] perf_stall_q;
  logic [CNT_W-1:0] perf_flush_q;
  logic [CNT_W-1:0] perf_mdu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_mdu_q   <= '0;
    end else begin
      if (stall_PC && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + CNT_ONE;
      if (flush_IF_ID && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + CNT_ONE;
      if (mdu_busy && (perf_mdu_q != '1)) perf_mdu_q <= perf_mdu_q + CNT_ONE;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
  assign perf_mdu   = perf_mdu_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
  assign perf_mdu   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 4;

  // {stall_PC, stall_IF_ID, stall_ID_EXE, stall_EXE_MEM, stall_MEM_WB, flush_IF_ID, flush_ID_EXE, mdu_start, mdu_busy, mdu_done}
  localparam logic [9:0] E_NONE  = 10'b00000_00_000;
  localparam logic [9:0] E_BUB   = 10'b11000_01_000;
  localparam logic [9:0] E_WAIT  = 10'b11111_00_000;
  localparam logic [9:0] E_FLUSH = 10'b00000_11_000;
  localparam logic [9:0] MS      = 10'b00000_00_100;
  localparam logic [9:0] MB      = 10'b00000_00_010;
  localparam logic [9:0] MD      = 10'b00000_00_001;

`ifdef HAZ_PERF_CNT_EN
  localparam int EXP_PSTALL = 15;
  localparam int EXP_PFLUSH = 3;
  localparam int EXP_PMDU   = MUL_LAT - 1;
`else
  localparam int EXP_PSTALL = 0;
  localparam int EXP_PFLUSH = 0;
  localparam int EXP_PMDU   = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs_ID, rt_ID, num_write_EXE;
  logic use_rs_ID, use_rt_ID, mem_read_EXE, reg_write_EXE, branch_taken_EXE;
  logic mdu_start_ID, mdu_is_div_ID, mdu_read_ID, dmem_wait;
  logic stall_PC, stall_IF_ID, stall_ID_EXE, stall_EXE_MEM, stall_MEM_WB;
  logic flush_IF_ID, flush_ID_EXE, mdu_start, mdu_busy, mdu_done;
  logic [CNT_W-1:0] perf_stall, perf_flush, perf_mdu;
  logic [9:0] obs;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rs_ID            (rs_ID),
    .rt_ID            (rt_ID),
    .use_rs_ID        (use_rs_ID),
    .use_rt_ID        (use_rt_ID),
    .num_write_EXE    (num_write_EXE),
    .mem_read_EXE     (mem_read_EXE),
    .reg_write_EXE    (reg_write_EXE),
    .branch_taken_EXE (branch_taken_EXE),
    .mdu_start_ID     (mdu_start_ID),
    .mdu_is_div_ID    (mdu_is_div_ID),
    .mdu_read_ID      (mdu_read_ID),
    .dmem_wait        (dmem_wait),
    .stall_PC         (stall_PC),
    .stall_IF_ID      (stall_IF_ID),
    .stall_ID_EXE     (stall_ID_EXE),
    .stall_EXE_MEM    (stall_EXE_MEM),
    .stall_MEM_WB     (stall_MEM_WB),
    .flush_IF_ID      (flush_IF_ID),
    .flush_ID_EXE     (flush_ID_EXE),
    .mdu_start        (mdu_start),
    .mdu_busy         (mdu_busy),
    .mdu_done         (mdu_done),
    .perf_stall       (perf_stall),
    .perf_flush       (perf_flush),
    .perf_mdu         (perf_mdu)
  );

  assign obs = {stall_PC, stall_IF_ID, stall_ID_EXE, stall_EXE_MEM, stall_MEM_WB,
                flush_IF_ID, flush_ID_EXE, mdu_start, mdu_busy, mdu_done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs_ID = 5'd0; rt_ID = 5'd0; num_write_EXE = 5'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; mem_read_EXE = 1'b0; reg_write_EXE = 1'b0;
    branch_taken_EXE = 1'b0; mdu_start_ID = 1'b0; mdu_is_div_ID = 1'b0;
    mdu_read_ID = 1'b0; dmem_wait = 1'b0;
  endtask

  // Push the expectation for this cycle, compare at the falling edge, return just after the next rising edge
  task automatic step(input string tag, input logic [9:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
    @(negedge clk);
    it = sb_q.pop_front();
    chk(it.tag, 32'(obs), 32'(it.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] dst);
    mem_read_EXE = 1'b1; reg_write_EXE = 1'b1; num_write_EXE = dst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_in();
    dmem_wait = 1'b1;
    branch_taken_EXE = 1'b1;
    #1;
    step("reset_forced_zero", E_NONE);
    chk("reset_perf_stall", 32'(perf_stall), 32'd0);
    clr_in();
    rst_n = 1'b1;
    step("idle_after_reset", E_NONE);

    // load-use
    rs_ID = 5'd5; use_rs_ID = 1'b1; set_load(5'd5);
    step("lu_rs", E_BUB);
    mem_read_EXE = 1'b0; reg_write_EXE = 1'b0;
    step("lu_released", E_NONE);
    set_load(5'd0); rs_ID = 5'd0;
    step("lu_r0", E_NONE);
    clr_in(); rt_ID = 5'd7; use_rt_ID = 1'b1; set_load(5'd7);
    step("lu_rt", E_BUB);
    use_rt_ID = 1'b0;
    step("lu_rt_unused", E_NONE);
    clr_in(); rs_ID = 5'd9; use_rs_ID = 1'b1; set_load(5'd9); reg_write_EXE = 1'b0;
    step("lu_nowrite", E_NONE);

    // branch beats load-use and blocks a wrong-path MDU start
    clr_in(); rs_ID = 5'd5; use_rs_ID = 1'b1; set_load(5'd5);
    branch_taken_EXE = 1'b1; mdu_start_ID = 1'b1;
    step("br_lu_mdu", E_FLUSH);
    clr_in();
    step("br_no_mdu_start", E_NONE);
    step("br_no_mdu_busy", E_NONE);

    // dmem_wait freezes a taken branch
    branch_taken_EXE = 1'b1; dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("dwait_%0d", i), E_WAIT);
    dmem_wait = 1'b0;
    step("dwait_release_flush", E_FLUSH);
    clr_in();

    // divide with mfhi waiting in ID; one dmem_wait cycle must not pause the count
    mdu_start_ID = 1'b1; mdu_is_div_ID = 1'b1;
    step("div_accept", E_NONE);
    clr_in(); mdu_read_ID = 1'b1;
    for (int k = 1; k < DIV_LAT; k++) begin
      dmem_wait = (k == 10);
      if (k == 10) step($sformatf("div_k%0d", k), E_WAIT | MB);
      else step($sformatf("div_k%0d", k), E_BUB | MB | ((k == 1) ? MS : E_NONE));
    end
    dmem_wait = 1'b0;
    step("div_done", MD);
    step("div_idle", E_NONE);
    clr_in();

    // back-to-back multiplies, second accepted in DONE
    mdu_start_ID = 1'b1;
    step("mul_accept", E_NONE);
    for (int r = 0; r < 2; r++) begin
      mdu_start_ID = 1'b0;
      for (int k = 1; k < MUL_LAT; k++)
        step($sformatf("mul%0d_k%0d", r, k), MB | ((k == 1) ? MS : E_NONE));
      mdu_start_ID = (r == 0);
      step($sformatf("mul%0d_done", r), MD);
    end
    mdu_start_ID = 1'b0;
    step("mul_idle", E_NONE);

    // asynchronous reset while BUSY aborts without mdu_done
    mdu_start_ID = 1'b1;
    step("abort_accept", E_NONE);
    mdu_start_ID = 1'b0;
    step("abort_busy1", MS | MB);
    dmem_wait = 1'b1; mdu_read_ID = 1'b1;
    #1;
    chk("abort_prereset", 32'(obs), 32'(E_WAIT | MB));
    rst_n = 1'b0;
    #1;
    chk("abort_async_zero", 32'(obs), 32'(E_NONE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_in();
    for (int i = 0; i < MUL_LAT + 2; i++) step($sformatf("abort_nodone_%0d", i), E_NONE);

    // performance counters from a fresh reset
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dmem_wait = 1'b1;
    for (int i = 0; i < 20; i++) step($sformatf("perf_wait_%0d", i), E_WAIT);
    dmem_wait = 1'b0; branch_taken_EXE = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("perf_br_%0d", i), E_FLUSH);
    clr_in();
    step("perf_gap", E_NONE);
    chk("perf_stall_sat", 32'(perf_stall), 32'(EXP_PSTALL));
    chk("perf_flush", 32'(perf_flush), 32'(EXP_PFLUSH));
    mdu_start_ID = 1'b1;
    step("perf_mul_accept", E_NONE);
    mdu_start_ID = 1'b0;
    for (int k = 1; k < MUL_LAT; k++)
      step($sformatf("perf_mul_k%0d", k), MB | ((k == 1) ? MS : E_NONE));
    step("perf_mul_done", MD);
    chk("perf_mdu", 32'(perf_mdu), 32'(EXP_PMDU));
    chk("perf_stall_hold", 32'(perf_stall), 32'(EXP_PSTALL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline stall/flush scheduler for the 5-stage MIPS core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, the multi-cycle mul/div unit (MDU), taken branches, and data-memory wait. It owns the MDU sequencing FSM and drives the per-stage stall and flush enables.

Parameters:
MUL_LAT, 4, multiply latency in cycles (>=2)
DIV_LAT, 32, divide latency in cycles (>=2)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
rs_ID  in  5  rs field of ID instruction
rt_ID  in  5  rt field of ID instruction
use_rs_ID  in  1  ID instruction reads rs
use_rt_ID  in  1  ID instruction reads rt
num_write_EXE  in  5  destination register in EXE
mem_read_EXE  in  1  EXE instruction is a load
reg_write_EXE  in  1  EXE instruction writes the register file
branch_taken_EXE  in  1  branch/jump resolved taken in EXE
mdu_start_ID  in  1  ID instruction is mult/multu/div/divu
mdu_is_div_ID  in  1  qualifies mdu_start_ID: 1 = divide
mdu_read_ID  in  1  ID instruction is mfhi/mflo
dmem_wait  in  1  data memory not ready
stall_PC  out  1  hold PC
stall_IF_ID  out  1  hold IF/ID register
stall_ID_EXE  out  1  hold ID/EXE register
stall_EXE_MEM  out  1  hold EXE/MEM register
stall_MEM_WB  out  1  hold MEM/WB register
flush_IF_ID  out  1  clear IF/ID register to NOP
flush_ID_EXE  out  1  insert bubble into ID/EXE register
mdu_start  out  1  one-cycle pulse that launches the MDU
mdu_busy  out  1  MDU operation in progress
mdu_done  out  1  one-cycle pulse; HI/LO valid
perf_stall  out  CNT_W  stall-cycle counter
perf_flush  out  CNT_W  flush-event counter
perf_mdu  out  CNT_W  MDU busy-cycle counter

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; the counter and all registered outputs clear to 0. The combinational stall/flush outputs are forced to 0 while rst_n=0.
- Hazard terms (combinational):
  - LU = mem_read_EXE & reg_write_EXE & num_write_EXE!=0 & ((use_rs_ID & rs_ID==num_write_EXE) | (use_rt_ID & rt_ID==num_write_EXE)).
  - MH = (state==BUSY) & (mdu_start_ID | mdu_read_ID).
- Priority, evaluated each cycle (highest first):
  1. dmem_wait=1: all five stall_* =1; both flushes =0; no MDU start. The MDU counter keeps running. branch_taken_EXE stays held because EXE is frozen, so its flush applies in the first cycle after dmem_wait falls.
  2. branch_taken_EXE=1: flush_IF_ID=1, flush_ID_EXE=1, all stalls =0. A wrong-path mdu_start_ID is not accepted.
  3. MH: stall_PC=1, stall_IF_ID=1, flush_ID_EXE=1; other stalls =0.
  4. LU: same outputs as MH. Exactly one bubble is inserted per load, because the load has then reached MEM and forwarding covers it.
  5. Otherwise all stall/flush outputs =0.
- MDU FSM:
  - IDLE: on mdu_start_ID with no higher-priority condition, assert mdu_start (registered, 1 cycle). Load cnt = (mdu_is_div_ID ? DIV_LAT : MUL_LAT) - 1 and go to BUSY.
  - BUSY: mdu_busy=1 and cnt decrements each cycle. When cnt==0, go to DONE.
  - DONE: lasts 1 cycle with mdu_done=1. mdu_read_ID is not stalled in this cycle. A new mdu_start_ID in DONE is accepted exactly as in IDLE (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: from the start-accept edge to mdu_done is exactly LAT cycles.
- cnt width is clog2(DIV_LAT).
- A reset in BUSY aborts the operation with no mdu_done.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: perf_stall increments on every cycle in which stall_PC=1. perf_flush increments on every cycle in which flush_IF_ID=1. perf_mdu increments on every BUSY cycle. All three saturate at all-ones and clear on reset.
- Undefined: the perf_* ports exist but are tied to 0, and no counter logic is generated.

Decomposition:
- Shared header hazard_define.v, included alongside func_define.v, holds:
  - FSM state encodings: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - default MUL_LAT/DIV_LAT values;
  - the HAZ_PERF_CNT_EN guard.
- One sub-module, mdu_seq_fsm, holds the FSM and down-counter and exports mdu_start/mdu_busy/mdu_done/state. The top module holds the priority logic and the perf counters.

Test Plan:
- lw $5 in EXE (mem_read_EXE=1, num_write_EXE=5), ID add with rs=5 -> one cycle of stall_PC=stall_IF_ID=flush_ID_EXE=1, then all 0. Repeat with num_write_EXE=0 -> no stall.
- div accepted at cycle t (DIV_LAT=32) -> mdu_busy set t+1..t+31, mdu_done=1 at t+32. mfhi in ID stalls through t+31 and proceeds at t+32.
- branch_taken_EXE and LU in the same cycle -> flush_IF_ID=flush_ID_EXE=1, stall_PC=0. A concurrent mdu_start_ID does not start the MDU.
- dmem_wait held 3 cycles with branch_taken_EXE=1 -> all stalls =1, flushes =0 for 3 cycles. Flushes assert in the 4th cycle.
- mult in BUSY (MUL_LAT=4), rst_n pulsed low mid-count -> outputs 0 immediately, FSM IDLE, no mdu_done afterward.
- With HAZ_PERF_CNT_EN and CNT_W=4: 20 stall cycles -> perf_stall=15 (saturated).
